// File: rtl/mips_pkg.sv
// Shared pipeline-control constants: forwarding selects and branch-resolve stage codes.
package mips_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_WB  = 2'd1;
    localparam fwd_sel_t FWD_MEM = 2'd2;

    localparam int BR_STAGE_EX  = 2;
    localparam int BR_STAGE_MEM = 3;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the 5-stage datapath (master) and the hazard/forwarding controller (slave).
interface pipe_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    // dm_ready is the only flow-control input: when low every stage holds and no
    // strobe fires; id_valid/v_* mark stages that carry a real instruction.
    logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt;
    logic [REG_AW-1:0] ex_wreg, mem_wreg, wb_wreg;
    logic              id_valid, ex_regwrite, mem_regwrite, wb_regwrite;
    logic              ex_memread, br_taken, dm_ready;
    logic              pc_we, ifid_we;
    logic              idex_bubble, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]        fwd_a, fwd_b;
    logic              v_ex, v_mem, v_wb;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    modport master (
        output id_rs, id_rt, id_valid, ex_rs, ex_rt,
        output ex_wreg, mem_wreg, wb_wreg,
        output ex_regwrite, mem_regwrite, wb_regwrite,
        output ex_memread, br_taken, dm_ready,
        input  pc_we, ifid_we, idex_bubble, ifid_flush, idex_flush, exmem_flush,
        input  fwd_a, fwd_b, v_ex, v_mem, v_wb, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_valid, ex_rs, ex_rt,
        input  ex_wreg, mem_wreg, wb_wreg,
        input  ex_regwrite, mem_regwrite, wb_regwrite,
        input  ex_memread, br_taken, dm_ready,
        output pc_we, ifid_we, idex_bubble, ifid_flush, idex_flush, exmem_flush,
        output fwd_a, fwd_b, v_ex, v_mem, v_wb, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_fwd_unit.sv
// Per-operand forwarding compare: picks MEM, then WB, then the register file.
module fwd_unit
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic [REG_AW-1:0] i_mem_wreg,
    input  logic              i_mem_regwrite,
    input  logic              i_v_mem,
    input  logic [REG_AW-1:0] i_wb_wreg,
    input  logic              i_wb_regwrite,
    input  logic              i_v_wb,
    output fwd_sel_t          o_sel
);

    logic w_mem_hit, w_wb_hit;

    // r0 is hardwired zero, so a write to it must never be forwarded.
    assign w_mem_hit = i_mem_regwrite & i_v_mem & (i_mem_wreg != '0) & (i_mem_wreg == i_src);
    assign w_wb_hit  = i_wb_regwrite  & i_v_wb  & (i_wb_wreg  != '0) & (i_wb_wreg  == i_src);

    always_comb begin
        o_sel = FWD_RF;
        if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard controller: load-use stall, branch flush, freeze, stage valids and
// optional event counters (enabled by defining PIPE_CTRL_PERF_EN).
module pipe_ctrl
    import mips_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int BR_STAGE = 3,
    parameter int CNT_W    = 32
) (
    input logic         clk,
    input logic         rst,
    pipe_ctrl_if.slave  bus
);

    logic             r_v_ex, r_v_mem, r_v_wb;
    logic             w_run, w_br_valid, w_br, w_exmem_flush;
    logic             w_load_hit, w_load_use, w_stall;
    logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

    // Nothing fires while in reset or while data memory freezes the pipe.
    assign w_run         = rst & bus.dm_ready;
    assign w_br_valid    = (BR_STAGE == BR_STAGE_EX) ? r_v_ex : r_v_mem;
    assign w_br          = w_run & bus.br_taken & w_br_valid;
    assign w_exmem_flush = w_br & (BR_STAGE == BR_STAGE_MEM);

    assign w_load_hit = (bus.ex_wreg == bus.id_rs) | (bus.ex_wreg == bus.id_rt);
    assign w_load_use = bus.ex_memread & bus.ex_regwrite & (bus.ex_wreg != '0)
                      & bus.id_valid & w_load_hit;
    // A taken branch kills the dependent instruction anyway, so it wins.
    assign w_stall    = w_run & w_load_use & ~w_br;

    assign bus.pc_we       = ~rst | (bus.dm_ready & ~w_stall);
    assign bus.ifid_we     = ~rst | (bus.dm_ready & ~w_stall);
    assign bus.idex_bubble = w_stall;
    assign bus.ifid_flush  = w_br;
    assign bus.idex_flush  = w_br;
    assign bus.exmem_flush = w_exmem_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v_ex  <= 1'b0;
            r_v_mem <= 1'b0;
            r_v_wb  <= 1'b0;
        end else if (bus.dm_ready) begin
            r_v_ex  <= bus.id_valid & ~w_stall & ~w_br;
            r_v_mem <= r_v_ex & ~w_exmem_flush;
            r_v_wb  <= r_v_mem;
        end
    end

    assign bus.v_ex  = r_v_ex;
    assign bus.v_mem = r_v_mem;
    assign bus.v_wb  = r_v_wb;

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .i_src          (bus.ex_rs),
        .i_mem_wreg     (bus.mem_wreg),
        .i_mem_regwrite (bus.mem_regwrite),
        .i_v_mem        (r_v_mem),
        .i_wb_wreg      (bus.wb_wreg),
        .i_wb_regwrite  (bus.wb_regwrite),
        .i_v_wb         (r_v_wb),
        .o_sel          (bus.fwd_a)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .i_src          (bus.ex_rt),
        .i_mem_wreg     (bus.mem_wreg),
        .i_mem_regwrite (bus.mem_regwrite),
        .i_v_mem        (r_v_mem),
        .i_wb_wreg      (bus.wb_wreg),
        .i_wb_regwrite  (bus.wb_regwrite),
        .i_v_wb         (r_v_wb),
        .o_sel          (bus.fwd_b)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    // Saturating counters; w_stall/w_br are already masked by freeze and reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_br && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign w_stall_cnt = r_stall_cnt;
    assign w_flush_cnt = r_flush_cnt;
`else
    assign w_stall_cnt = '0;
    assign w_flush_cnt = '0;
`endif

    assign bus.stall_cnt = w_stall_cnt;
    assign bus.flush_cnt = w_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a MEM-resolving instance (32-bit counters) and an
// EX-resolving instance (2-bit counters) share one stimulus stream.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    typedef struct {
        logic [4:0] id_rs, id_rt;
        logic       id_valid;
        logic [4:0] ex_rs, ex_rt, ex_wreg;
        logic       ex_rw, ex_mr;
        logic [4:0] mem_wreg;
        logic       mem_rw;
        logic [4:0] wb_wreg;
        logic       wb_rw;
        logic       br, dm;
    } in_t;

    typedef struct {
        in_t        i;
        logic       pc_we, ifid_we, bub, fl, em;
        logic [1:0] fa, fb;
    } vec_t;

    logic clk;
    logic rst;
    in_t  cur;
    in_t  clean, loaduse;
    vec_t tbl[15];
    int   n_checks;
    int   n_errors;
    int   exp_stall;
    int   exp_flush;

    pipe_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus1 ();
    pipe_ctrl_if #(.REG_AW(5), .CNT_W(2))  bus2 ();

    pipe_ctrl #(.REG_AW(5), .BR_STAGE(3), .CNT_W(32)) dut (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );
    pipe_ctrl #(.REG_AW(5), .BR_STAGE(2), .CNT_W(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave)
    );

    assign bus1.id_rs = cur.id_rs;       assign bus2.id_rs = cur.id_rs;
    assign bus1.id_rt = cur.id_rt;       assign bus2.id_rt = cur.id_rt;
    assign bus1.id_valid = cur.id_valid; assign bus2.id_valid = cur.id_valid;
    assign bus1.ex_rs = cur.ex_rs;       assign bus2.ex_rs = cur.ex_rs;
    assign bus1.ex_rt = cur.ex_rt;       assign bus2.ex_rt = cur.ex_rt;
    assign bus1.ex_wreg = cur.ex_wreg;   assign bus2.ex_wreg = cur.ex_wreg;
    assign bus1.ex_regwrite = cur.ex_rw; assign bus2.ex_regwrite = cur.ex_rw;
    assign bus1.ex_memread = cur.ex_mr;  assign bus2.ex_memread = cur.ex_mr;
    assign bus1.mem_wreg = cur.mem_wreg; assign bus2.mem_wreg = cur.mem_wreg;
    assign bus1.mem_regwrite = cur.mem_rw; assign bus2.mem_regwrite = cur.mem_rw;
    assign bus1.wb_wreg = cur.wb_wreg;   assign bus2.wb_wreg = cur.wb_wreg;
    assign bus1.wb_regwrite = cur.wb_rw; assign bus2.wb_regwrite = cur.wb_rw;
    assign bus1.br_taken = cur.br;       assign bus2.br_taken = cur.br;
    assign bus1.dm_ready = cur.dm;       assign bus2.dm_ready = cur.dm;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(input int id_rs, input int id_rt, input int id_v,
                                  input int ex_rs, input int ex_rt, input int ex_wreg,
                                  input int ex_rw, input int ex_mr, input int mem_wreg,
                                  input int mem_rw, input int wb_wreg, input int wb_rw,
                                  input int br, input int dm);
        in_t r;
        r.id_rs = 5'(id_rs);   r.id_rt = 5'(id_rt);   r.id_valid = 1'(id_v);
        r.ex_rs = 5'(ex_rs);   r.ex_rt = 5'(ex_rt);   r.ex_wreg = 5'(ex_wreg);
        r.ex_rw = 1'(ex_rw);   r.ex_mr = 1'(ex_mr);
        r.mem_wreg = 5'(mem_wreg); r.mem_rw = 1'(mem_rw);
        r.wb_wreg = 5'(wb_wreg);   r.wb_rw = 1'(wb_rw);
        r.br = 1'(br);         r.dm = 1'(dm);
        return r;
    endfunction

    function automatic vec_t mk_v(input in_t i, input int pc, input int ifw, input int bub,
                                  input int fl, input int em, input int fa, input int fb);
        vec_t v;
        v.i = i;
        v.pc_we = 1'(pc); v.ifid_we = 1'(ifw); v.bub = 1'(bub);
        v.fl = 1'(fl);    v.em = 1'(em);
        v.fa = 2'(fa);    v.fb = 2'(fb);
        return v;
    endfunction

    function automatic logic [31:0] pexp(input int v);
        return 32'(v * PERF);
    endfunction

    // driver / checker tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkc(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clean   = mk_in(1, 2, 1, 3, 4, 5, 1, 0, 6, 1, 7, 1, 0, 1);
        loaduse = mk_in(8, 2, 1, 3, 4, 8, 1, 1, 6, 1, 7, 1, 0, 1);

        //                 id_rs rt v ex_rs rt wreg rw mr mem rw wb rw br dm   pc ifw bub fl em fa fb
        tbl[0]  = mk_v(mk_in(1, 2, 1,  3,  4, 5, 1, 0,  6, 1,  7, 1, 0, 1), 1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk_v(mk_in(8, 2, 1,  3,  4, 8, 1, 1,  6, 1,  7, 1, 0, 1), 0, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk_v(mk_in(1, 8, 1,  3,  4, 8, 1, 1,  6, 1,  7, 1, 0, 1), 0, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk_v(mk_in(0, 2, 1,  3,  4, 0, 1, 1,  6, 1,  7, 1, 0, 1), 1, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk_v(mk_in(8, 2, 0,  3,  4, 8, 1, 1,  6, 1,  7, 1, 0, 1), 1, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk_v(mk_in(8, 2, 1,  3,  4, 8, 0, 1,  6, 1,  7, 1, 0, 1), 1, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk_v(mk_in(1, 2, 1,  9,  4, 5, 1, 0,  9, 1,  9, 1, 0, 1), 1, 1, 0, 0, 0, 2, 0);
        tbl[7]  = mk_v(mk_in(1, 2, 1,  9,  4, 5, 1, 0,  6, 1,  9, 1, 0, 1), 1, 1, 0, 0, 0, 1, 0);
        tbl[8]  = mk_v(mk_in(1, 2, 1,  0,  0, 5, 1, 0,  0, 1,  0, 1, 0, 1), 1, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk_v(mk_in(1, 2, 1, 11, 10, 5, 1, 0, 10, 1, 11, 1, 0, 1), 1, 1, 0, 0, 0, 1, 2);
        tbl[10] = mk_v(mk_in(1, 2, 1, 12,  4, 5, 1, 0, 12, 0, 12, 1, 0, 1), 1, 1, 0, 0, 0, 1, 0);
        tbl[11] = mk_v(mk_in(1, 2, 1,  3,  4, 5, 1, 0,  6, 1,  7, 1, 1, 1), 1, 1, 0, 1, 1, 0, 0);
        tbl[12] = mk_v(mk_in(8, 2, 1,  3,  4, 8, 1, 1,  6, 1,  7, 1, 1, 1), 1, 1, 0, 1, 1, 0, 0);
        tbl[13] = mk_v(mk_in(8, 2, 1,  3,  4, 8, 1, 1,  6, 1,  7, 1, 1, 0), 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk_v(mk_in(1, 2, 1, 13, 13, 5, 1, 0, 13, 1, 13, 1, 0, 1), 1, 1, 0, 0, 0, 2, 2);

        // reset: hazards and forwarding candidates on the inputs must be ignored
        rst = 1'b1;
        cur = mk_in(8, 2, 1, 3, 4, 8, 1, 1, 3, 1, 3, 1, 1, 1);
        #1 rst = 1'b0;
        #2;
        chk1("rst pc_we", bus1.pc_we, 1'b1);
        chk1("rst ifid_we", bus1.ifid_we, 1'b1);
        chk1("rst idex_bubble", bus1.idex_bubble, 1'b0);
        chk1("rst ifid_flush", bus1.ifid_flush, 1'b0);
        chk1("rst exmem_flush", bus1.exmem_flush, 1'b0);
        chk2("rst fwd_a", bus1.fwd_a, 2'd0);
        chk1("rst v_ex", bus1.v_ex, 1'b0);
        chk1("rst v_mem", bus1.v_mem, 1'b0);
        chk1("rst v_wb", bus1.v_wb, 1'b0);
        chkc("rst stall_cnt", bus1.stall_cnt, 32'd0);
        chkc("rst flush_cnt", bus1.flush_cnt, 32'd0);

        // load-use stall from an empty pipe
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        cur = loaduse;
        #1;
        chk1("lu pc_we", bus1.pc_we, 1'b0);
        chk1("lu ifid_we", bus1.ifid_we, 1'b0);
        chk1("lu idex_bubble", bus1.idex_bubble, 1'b1);
        exp_stall = 1;
        tick();
        cur = clean;
        #1;
        chk1("lu+1 pc_we", bus1.pc_we, 1'b1);
        chk1("lu+1 idex_bubble", bus1.idex_bubble, 1'b0);
        chk1("lu+1 v_ex", bus1.v_ex, 1'b0);
        chkc("lu+1 stall_cnt", bus1.stall_cnt, pexp(exp_stall));

        // branch resolved in MEM
        tick();
        tick();
        cur.br = 1'b1;
        #1;
        chk1("br v_mem before", bus1.v_mem, 1'b1);
        chk1("br ifid_flush", bus1.ifid_flush, 1'b1);
        chk1("br idex_flush", bus1.idex_flush, 1'b1);
        chk1("br exmem_flush", bus1.exmem_flush, 1'b1);
        chk1("br pc_we", bus1.pc_we, 1'b1);
        exp_flush = 1;
        tick();
        cur.br = 1'b0;
        #1;
        chk1("br+1 v_ex", bus1.v_ex, 1'b0);
        chk1("br+1 v_mem", bus1.v_mem, 1'b0);
        chk1("br+1 ifid_flush", bus1.ifid_flush, 1'b0);
        chkc("br+1 flush_cnt", bus1.flush_cnt, pexp(exp_flush));
        cur.br = 1'b1;
        #1;
        chk1("br invalid ifid_flush", bus1.ifid_flush, 1'b0);
        chk1("br invalid exmem_flush", bus1.exmem_flush, 1'b0);
        tick();
        cur.br = 1'b0;

        // freeze with a pending branch, then release
        tick();
        tick();
        tick();
        cur.dm = 1'b0;
        cur.br = 1'b1;
        cur.id_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("frz pc_we", bus1.pc_we, 1'b0);
            chk1("frz ifid_we", bus1.ifid_we, 1'b0);
            chk1("frz ifid_flush", bus1.ifid_flush, 1'b0);
            chk1("frz exmem_flush", bus1.exmem_flush, 1'b0);
            chk1("frz idex_bubble", bus1.idex_bubble, 1'b0);
            chk1("frz v_ex", bus1.v_ex, 1'b1);
            chk1("frz v_mem", bus1.v_mem, 1'b1);
            chk1("frz v_wb", bus1.v_wb, 1'b1);
            chkc("frz stall_cnt", bus1.stall_cnt, pexp(exp_stall));
            chkc("frz flush_cnt", bus1.flush_cnt, pexp(exp_flush));
            tick();
        end
        cur.dm = 1'b1;
        cur.id_valid = 1'b1;
        #1;
        chk1("unfrz ifid_flush", bus1.ifid_flush, 1'b1);
        chk1("unfrz exmem_flush", bus1.exmem_flush, 1'b1);
        chk1("unfrz pc_we", bus1.pc_we, 1'b1);
        exp_flush++;
        tick();
        cur.br = 1'b0;
        #1;
        chkc("unfrz flush_cnt", bus1.flush_cnt, pexp(exp_flush));
        chk1("unfrz v_mem", bus1.v_mem, 1'b0);

        // vector table, each row entered with all stages valid
        cur = clean;
        tick();
        tick();
        tick();
        for (int k = 0; k < 15; k++) begin
            cur = tbl[k].i;
            #1;
            chk1($sformatf("row%0d pc_we", k), bus1.pc_we, tbl[k].pc_we);
            chk1($sformatf("row%0d ifid_we", k), bus1.ifid_we, tbl[k].ifid_we);
            chk1($sformatf("row%0d idex_bubble", k), bus1.idex_bubble, tbl[k].bub);
            chk1($sformatf("row%0d ifid_flush", k), bus1.ifid_flush, tbl[k].fl);
            chk1($sformatf("row%0d idex_flush", k), bus1.idex_flush, tbl[k].fl);
            chk1($sformatf("row%0d exmem_flush", k), bus1.exmem_flush, tbl[k].em);
            chk2($sformatf("row%0d fwd_a", k), bus1.fwd_a, tbl[k].fa);
            chk2($sformatf("row%0d fwd_b", k), bus1.fwd_b, tbl[k].fb);
            if (tbl[k].bub) exp_stall++;
            if (tbl[k].fl) exp_flush++;
            tick();
            cur = clean;
            tick();
            tick();
            tick();
        end
        #1;
        chkc("tbl stall_cnt", bus1.stall_cnt, pexp(exp_stall));
        chkc("tbl flush_cnt", bus1.flush_cnt, pexp(exp_flush));
        chkc("tbl dut2 stall_cnt", 32'(bus2.stall_cnt), pexp(3));

        // one more stall: 2-bit counter of dut2 must stay at all-ones
        cur = loaduse;
        #1;
        chk1("sat idex_bubble", bus1.idex_bubble, 1'b1);
        exp_stall++;
        tick();
        cur = clean;
        #1;
        chkc("sat stall_cnt", bus1.stall_cnt, pexp(exp_stall));
        chkc("sat dut2 stall_cnt", 32'(bus2.stall_cnt), pexp(3));

        // asynchronous reset in the middle of a stall
        tick();
        cur = loaduse;
        #1;
        chk1("mid idex_bubble", bus1.idex_bubble, 1'b1);
        chk1("mid v_ex", bus1.v_ex, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("arst v_ex", bus1.v_ex, 1'b0);
        chk1("arst v_mem", bus1.v_mem, 1'b0);
        chk1("arst v_wb", bus1.v_wb, 1'b0);
        chkc("arst stall_cnt", bus1.stall_cnt, 32'd0);
        chkc("arst flush_cnt", bus1.flush_cnt, 32'd0);
        chk1("arst pc_we", bus1.pc_we, 1'b1);
        chk1("arst idex_bubble", bus1.idex_bubble, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        cur = clean;
        cur.br = 1'b1;
        #1;
        chk1("rel ifid_flush", bus1.ifid_flush, 1'b0);
        chk1("rel dut2 ifid_flush", bus2.ifid_flush, 1'b0);
        chk1("rel pc_we", bus1.pc_we, 1'b1);
        chk1("rel v_ex", bus1.v_ex, 1'b0);

        // branch resolved in EX on dut2
        tick();
        #1;
        chk1("ex dut2 ifid_flush", bus2.ifid_flush, 1'b1);
        chk1("ex dut2 idex_flush", bus2.idex_flush, 1'b1);
        chk1("ex dut2 exmem_flush", bus2.exmem_flush, 1'b0);
        chk1("ex dut1 ifid_flush", bus1.ifid_flush, 1'b0);
        tick();
        cur.br = 1'b0;
        #1;
        chk1("ex+1 dut2 v_ex", bus2.v_ex, 1'b0);
        chk1("ex+1 dut2 v_mem", bus2.v_mem, 1'b1);
        chkc("ex+1 dut2 flush_cnt", 32'(bus2.flush_cnt), pexp(1));
        chkc("ex+1 dut1 flush_cnt", bus1.flush_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter BR_STAGE, default 3, stage resolving branches/jumps (2=EX, 3=MEM).
REQ-003 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-004 Ports (name direction width meaning):
 clk input 1 single clock, all state on rising edge;
 rst input 1 asynchronous, active-low reset;
 id_rs, id_rt input REG_AW ID-stage source registers;
 id_valid input 1 ID holds a real instruction;
 ex_rs, ex_rt input REG_AW EX-stage source registers;
 ex_wreg, mem_wreg, wb_wreg input REG_AW destination per stage;
 ex_regwrite, mem_regwrite, wb_regwrite input 1 write enables per stage;
 ex_memread input 1 EX instruction is a load;
 br_taken input 1 branch/jump taken at stage BR_STAGE;
 dm_ready input 1 data memory ready, 0 freezes pipeline;
 pc_we, ifid_we output 1 PC and IF/ID write enables;
 idex_bubble, ifid_flush, idex_flush, exmem_flush output 1 bubble/flush strobes;
 fwd_a, fwd_b output 2 EX operand select (0 regfile, 1 WB, 2 MEM);
 v_ex, v_mem, v_wb output 1 registered stage valid bits;
 stall_cnt, flush_cnt output CNT_W event counters.

Function
REQ-005 Load-use: ex_memread=1, ex_regwrite=1, ex_wreg!=0, id_valid=1, ex_wreg equals id_rs or id_rt -> pc_we=0, ifid_we=0, idex_bubble=1 for exactly one cycle.
REQ-006 fwd_a=2 when mem_regwrite, mem_wreg!=0, mem_wreg==ex_rs, v_mem; else 1 when same for WB with v_wb; else 0; fwd_b identical on ex_rt.
REQ-007 MEM forwarding SHALL take priority over WB when both match.
REQ-008 Register 0 SHALL never be forwarded or cause a stall.
REQ-009 br_taken with BR_STAGE=2: ifid_flush=1, idex_flush=1 same cycle; with BR_STAGE=3: additionally exmem_flush=1.
REQ-010 Flush SHALL override load-use stall in the same cycle: pc_we=1, no bubble counted.
REQ-011 dm_ready=0 SHALL freeze: pc_we=0, ifid_we=0, all flush/bubble strobes 0, valid bits and counters hold; br_taken ignored until dm_ready=1.
REQ-012 Valid pipeline (each edge, not frozen): v_ex<=id_valid & ~bubble & ~idex_flush; v_mem<=v_ex & ~exmem_flush (BR_STAGE=3) or v_ex; v_wb<=v_mem.
REQ-013 br_taken SHALL be qualified by the valid bit of stage BR_STAGE; invalid stage -> no flush.
REQ-014 Control outputs (pc_we, ifid_we, strobes, fwd) SHALL be combinational from inputs and valid bits; zero added latency.
REQ-015 stall_cnt +1 per load-use bubble cycle, flush_cnt +1 per flush cycle; both saturate at all-ones, no wrap.

Reset
REQ-016 rst=0 SHALL asynchronously clear v_ex, v_mem, v_wb and both counters; during reset pc_we=1, ifid_we=1, all strobes 0, fwd_a=fwd_b=0.
REQ-017 Reset asserted mid-stall or mid-flush SHALL abandon it; first cycle after release behaves as empty pipeline.

Configuration
REQ-018 Macro PIPE_CTRL_PERF_EN: defined -> counters per REQ-015; undefined -> counter registers absent, stall_cnt and flush_cnt tied to 0.

Structure
REQ-019 Shared package mips_pkg SHALL hold fwd-select constants (FWD_RF=0, FWD_WB=1, FWD_MEM=2) and BR_STAGE encodings.
REQ-020 One sub-module fwd_unit (per-operand forwarding compare) instanced twice; stall/flush/valid logic in pipe_ctrl.

Verification
REQ-021 ex_memread=1, ex_wreg=8, id_rs=8, id_valid=1 -> one cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle pc_we=1; stall_cnt=1.
REQ-022 mem_wreg=wb_wreg=9, both regwrite, valid, ex_rs=9 -> fwd_a=2; clear MEM match -> fwd_a=1; ex_rs=0 -> fwd_a=0.
REQ-023 BR_STAGE=3, v_mem=1, br_taken=1 -> ifid/idex/exmem flush=1 one cycle, flush_cnt=1, v_mem=0 next cycle.
REQ-024 Load-use and br_taken same cycle -> flush asserted, idex_bubble=0, pc_we=1, stall_cnt unchanged.
REQ-025 dm_ready=0 for 3 cycles with br_taken=1 -> no flush, valids and counters hold; dm_ready=1 -> flush proceeds.
REQ-026 rst=0 asynchronously mid-stall -> valids, counters 0 immediately; without PIPE_CTRL_PERF_EN counters read 0 throughout.
